aes_avalon_ctrl: RTL and testbench
==================================

Name: aes_avalon_ctrl

Overview:
Avalon-MM slave register front-end that sits directly upstream of the AES decryption core. It holds the 128-bit key and ciphertext written by the NIOS II software and drives them onto the core. It sequences the START/DONE handshake and captures the decrypted result into read-only registers for software polling. It also exports a 32-bit word for the hex display.

Parameters:
DISP_WORD, 0, index 0-3 of the captured plaintext word driven onto EXPORT_DATA (word 0 = bits 127:96).

Ports:
CLK  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
AVL_CS  in  1  Avalon chip select; AVL_READ and AVL_WRITE are ignored when low
AVL_READ  in  1  Avalon read strobe
AVL_WRITE  in  1  Avalon write strobe
AVL_ADDR  in  4  word address 0-15
AVL_BYTE_EN  in  4  byte enables, bit i selects WRITEDATA[8i+7:8i]
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  registered read data
AES_KEY  out  128  key to core, {reg0,reg1,reg2,reg3}
AES_MSG_ENC  out  128  ciphertext to core, {reg4,reg5,reg6,reg7}
AES_START  out  1  core start, level-held while running
AES_DONE  in  1  core completion, level
AES_MSG_DEC  in  128  plaintext from core
EXPORT_DATA  out  32  plaintext word DISP_WORD for the hex display

Behaviour:
- Register map, 32-bit words:
  - 0-3 KEY, read/write.
  - 4-7 ENC, read/write.
  - 8-11 DEC, read-only, captured from AES_MSG_DEC.
  - 12-13 scratch, read/write, no effect.
  - 14 CTRL: bit0 = START, read/write.
  - 15 STATUS, read-only: bit0 = DONE, bit1 = BUSY, other bits 0.
- Word 0 of each 128-bit group maps to bits 127:96.
- Writes honour AVL_BYTE_EN per byte. Writes to 8-11 and 15 are ignored.
- Read latency is 1 cycle: AVL_READDATA updates on the edge after a sampled AVL_CS&AVL_READ and otherwise holds its value. A read and a write to the same address in the same cycle return the pre-write value.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on a write to CTRL with bit0=1 (byte 0 enabled). AES_START goes high the cycle after the write edge. BUSY=1.
  - RUN: AES_START=1. Writes to KEY and ENC are dropped, so core inputs stay stable. Writes to CTRL are ignored.
  - RUN -> DONE: on the first edge with AES_DONE=1, regs 8-11 <= AES_MSG_DEC on that same edge. AES_START=0 and BUSY=0 from the next cycle; DONE=1.
  - DONE -> IDLE: on a write to CTRL with bit0=0, DONE is cleared. A write with bit0=1 in DONE goes directly to RUN and clears DONE.
- CTRL bit0 reads back the last accepted written value.
- AES_DONE while in IDLE or DONE is ignored. AES_START is never high outside RUN.
- EXPORT_DATA is the DEC register word DISP_WORD, combinational from the register.
- Reset (RESET_N low, any time including mid-RUN):
  - All registers, AVL_READDATA and EXPORT_DATA go to 0; state goes to IDLE.
  - AES_START=0 immediately, without waiting for a clock.
  - After release, the first transaction is accepted on the first clock edge.

Test Plan:
1. Reset, then write regs 0-3 = 00010203,04050607,08090a0b,0c0d0e0f and regs 4-7 = daec3055,df058e1c,39e814ea,76f6747e -> AES_KEY = 000102030405060708090a0b0c0d0e0f and AES_MSG_ENC = daec3055df058e1c39e814ea76f6747e. Read-back of each word returns the written value 1 cycle after AVL_READ.
2. Write CTRL=1; model the core raising AES_DONE 12 cycles later with AES_MSG_DEC = 00112233445566778899aabbccddeeff:
   - AES_START is high from cycle +1 until the cycle after DONE.
   - STATUS reads 2 while running, 1 after completion.
   - Regs 8-11 read 00112233, 44556677, 8899aabb, ccddeeff.
   - EXPORT_DATA = 00112233 with DISP_WORD=0.
   Then write CTRL=0 -> STATUS=0.
3. While in RUN, write reg0=ffffffff and reg14=0 -> AES_KEY unchanged, state stays RUN.
4. Write reg12 = 11223344 with AVL_BYTE_EN=0101 over an initial value of 0 -> read returns 00220044. Write reg9 = ffffffff -> read of reg9 is unchanged.
5. Assert RESET_N low 3 cycles into RUN -> AES_START drops without a clock edge; all reads return 0 after release. A new START runs normally.
6. Write ENC and read the same address in the same cycle -> returned data is the old value; the next read returns the new value.

Source files
------------

// File: rtl/aes_avalon_ctrl.sv
// Avalon-MM register front-end for the AES decryption core: key/ciphertext holding
// registers, START/DONE sequencing and capture of the decrypted result.
module aes_avalon_ctrl #(
    parameter int unsigned DISP_WORD = 0
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_DEC,
    output logic [31:0]  EXPORT_DATA
);

    // Handshake: a bus transfer happens on any edge where AVL_CS is high together
    // with AVL_READ and/or AVL_WRITE; there is no wait-request, every transfer
    // completes in that cycle and read data appears one edge later.

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int unsigned DispIdx = 8 + DISP_WORD;

    state_t              state_q, state_d;
    logic [13:0][31:0]   regs_q, regs_d;
    logic                ctrl_q, ctrl_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rd_word;
    logic                wr_en, rd_en;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign wr_en = AVL_CS & AVL_WRITE;
    assign rd_en = AVL_CS & AVL_READ;

    always_comb begin
        rd_word = '0;
        case (AVL_ADDR)
            4'd14:   rd_word = {31'd0, ctrl_q};
            4'd15:   rd_word = {30'd0, state_q == ST_RUN, state_q == ST_DONE};
            default: rd_word = regs_q[AVL_ADDR];
        endcase
    end

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;

        // The read mux looks at the current registers, so a same-cycle write is not visible yet.
        if (rd_en) rdata_d = rd_word;

        if (wr_en) begin
            case (AVL_ADDR)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                    if (state_q != ST_RUN)
                        regs_d[AVL_ADDR] = merge_bytes(regs_q[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
                end
                4'd12, 4'd13: begin
                    regs_d[AVL_ADDR] = merge_bytes(regs_q[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
                end
                4'd14: begin
                    if (state_q != ST_RUN && AVL_BYTE_EN[0]) begin
                        ctrl_d  = AVL_WRITEDATA[0];
                        state_d = AVL_WRITEDATA[0] ? ST_RUN : ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == ST_RUN && AES_DONE) begin
            regs_d[8]  = AES_MSG_DEC[127:96];
            regs_d[9]  = AES_MSG_DEC[95:64];
            regs_d[10] = AES_MSG_DEC[63:32];
            regs_d[11] = AES_MSG_DEC[31:0];
            state_d    = ST_DONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            regs_q  <= '0;
            ctrl_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
        end
    end

    // START is decoded from the state register, so the async reset drops it at once.
    assign AES_START    = (state_q == ST_RUN);
    assign AVL_READDATA = rdata_q;
    assign AES_KEY      = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
    assign AES_MSG_ENC  = {regs_q[4], regs_q[5], regs_q[6], regs_q[7]};
    assign EXPORT_DATA  = regs_q[DispIdx[3:0]];

endmodule

// File: tb/tb_aes_avalon_ctrl.sv
// Directed bench for aes_avalon_ctrl: register map table plus START/DONE, RUN lockout,
// mid-run reset and same-cycle read/write sequences.
module tb_aes_avalon_ctrl;

  logic         clk;
  logic         rst_n;
  logic         cs, rd, wr;
  logic [3:0]   addr;
  logic [3:0]   byte_en;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [127:0] aes_key, aes_enc, aes_dec;
  logic         aes_start, aes_done;
  logic [31:0]  export_data;

  int n_pass;
  int n_total;
  logic [31:0] exp_q[$];

  aes_avalon_ctrl #(.DISP_WORD(0)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .AVL_CS(cs),
    .AVL_READ(rd),
    .AVL_WRITE(wr),
    .AVL_ADDR(addr),
    .AVL_BYTE_EN(byte_en),
    .AVL_WRITEDATA(wdata),
    .AVL_READDATA(rdata),
    .AES_KEY(aes_key),
    .AES_MSG_ENC(aes_enc),
    .AES_START(aes_start),
    .AES_DONE(aes_done),
    .AES_MSG_DEC(aes_dec),
    .EXPORT_DATA(export_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[32];
  int   n_vecs;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks: called at a negedge, return at the following negedge
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; byte_en = be;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; byte_en = 4'h0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic add_vec(input bit r, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    vecs[n_vecs] = '{is_read: r, addr: a, be: be, data: d};
    n_vecs++;
  endtask

  logic [31:0] rv;
  logic [127:0] key_before;

  initial begin
    n_pass = 0; n_total = 0; n_vecs = 0;
    cs = 0; rd = 0; wr = 0; addr = 0; byte_en = 0; wdata = 0;
    aes_done = 0; aes_dec = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    check("reset_readdata", rdata, 0);
    check("reset_start", aes_start, 0);
    check("reset_export", export_data, 0);
    check("reset_key", aes_key, 0);

    // DONE while IDLE must not capture anything
    aes_done = 1'b1; aes_dec = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    repeat (2) @(negedge clk);
    aes_done = 1'b0;
    check("idle_done_no_start", aes_start, 0);

    add_vec(0, 4'd0, 4'hf, 32'h00010203);
    add_vec(0, 4'd1, 4'hf, 32'h04050607);
    add_vec(0, 4'd2, 4'hf, 32'h08090a0b);
    add_vec(0, 4'd3, 4'hf, 32'h0c0d0e0f);
    add_vec(0, 4'd4, 4'hf, 32'hdaec3055);
    add_vec(0, 4'd5, 4'hf, 32'hdf058e1c);
    add_vec(0, 4'd6, 4'hf, 32'h39e814ea);
    add_vec(0, 4'd7, 4'hf, 32'h76f6747e);
    add_vec(1, 4'd0, 4'h0, 32'h00010203);
    add_vec(1, 4'd1, 4'h0, 32'h04050607);
    add_vec(1, 4'd2, 4'h0, 32'h08090a0b);
    add_vec(1, 4'd3, 4'h0, 32'h0c0d0e0f);
    add_vec(1, 4'd4, 4'h0, 32'hdaec3055);
    add_vec(1, 4'd5, 4'h0, 32'hdf058e1c);
    add_vec(1, 4'd6, 4'h0, 32'h39e814ea);
    add_vec(1, 4'd7, 4'h0, 32'h76f6747e);
    add_vec(1, 4'd8, 4'h0, 32'h00000000);
    add_vec(0, 4'd12, 4'b0101, 32'h11223344);
    add_vec(1, 4'd12, 4'h0, 32'h00220044);
    add_vec(0, 4'd13, 4'hf, 32'hcafef00d);
    add_vec(1, 4'd13, 4'h0, 32'hcafef00d);
    add_vec(0, 4'd9, 4'hf, 32'hffffffff);
    add_vec(1, 4'd9, 4'h0, 32'h00000000);
    add_vec(0, 4'd15, 4'hf, 32'hffffffff);
    add_vec(1, 4'd15, 4'h0, 32'h00000000);
    add_vec(0, 4'd14, 4'b1110, 32'h00000001);
    add_vec(1, 4'd14, 4'h0, 32'h00000000);
    add_vec(1, 4'd15, 4'h0, 32'h00000000);

    for (int i = 0; i < n_vecs; i++) begin
      if (vecs[i].is_read) begin
        do_read(vecs[i].addr, rv);
        check($sformatf("table_read_%0d_addr%0d", i, vecs[i].addr), rv, vecs[i].data);
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      end
    end
    check("key_out", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("enc_out", aes_enc, 128'hdaec3055df058e1c39e814ea76f6747e);
    check("start_still_idle", aes_start, 0);

    // start a run; core answers 12 cycles after the CTRL write edge
    do_write(4'd14, 32'h1, 4'h1);
    check("start_cycle1", aes_start, 1);
    do_read(4'd15, rv);
    check("status_running", rv, 32'd2);
    key_before = aes_key;
    do_write(4'd0, 32'hffffffff, 4'hf);
    do_write(4'd14, 32'h0, 4'hf);
    check("run_key_locked", aes_key, key_before);
    check("run_start_held", aes_start, 1);
    do_read(4'd14, rv);
    check("run_ctrl_locked", rv, 32'd1);
    do_read(4'd15, rv);
    check("run_status_locked", rv, 32'd2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("start_wait_%0d", c), aes_start, 1);
    end
    aes_done = 1'b1;
    aes_dec  = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    aes_done = 1'b0;
    aes_dec  = '0;
    check("start_dropped", aes_start, 0);
    check("export_word0", export_data, 32'h00112233);
    do_read(4'd15, rv);
    check("status_done", rv, 32'd1);
    exp_q.push_back(32'h00112233);
    exp_q.push_back(32'h44556677);
    exp_q.push_back(32'h8899aabb);
    exp_q.push_back(32'hccddeeff);
    for (int a = 8; a < 12; a++) begin
      do_read(4'(a), rv);
      check($sformatf("dec_reg%0d", a), rv, exp_q.pop_front());
    end
    do_write(4'd9, 32'hffffffff, 4'hf);
    do_read(4'd9, rv);
    check("dec_reg9_readonly", rv, 32'h44556677);
    do_write(4'd14, 32'h0, 4'h1);
    do_read(4'd15, rv);
    check("status_cleared", rv, 32'd0);
    do_read(4'd14, rv);
    check("ctrl_readback0", rv, 32'd0);

    // same-cycle read and write of ENC word 0
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd4; wdata = 32'h55aa55aa; byte_en = 4'hf;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0; byte_en = 4'h0;
    check("rw_same_cycle_old", rdata, 32'hdaec3055);
    do_read(4'd4, rv);
    check("rw_next_read_new", rv, 32'h55aa55aa);

    // reset in the middle of a run
    do_write(4'd14, 32'h1, 4'hf);
    repeat (3) @(negedge clk);
    check("pre_reset_start", aes_start, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_start_drop", aes_start, 0);
    check("async_export_zero", export_data, 0);
    check("async_key_zero", aes_key, 0);
    check("async_readdata_zero", rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), rv);
      check($sformatf("post_reset_addr%0d", a), rv, 32'd0);
    end
    do_write(4'd14, 32'h1, 4'h1);
    check("restart_start", aes_start, 1);
    repeat (4) @(negedge clk);
    aes_done = 1'b1;
    aes_dec  = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    aes_done = 1'b0;
    check("restart_start_drop", aes_start, 0);
    check("restart_export", export_data, 32'h01234567);
    do_read(4'd15, rv);
    check("restart_status_done", rv, 32'd1);
    do_read(4'd11, rv);
    check("restart_dec_reg11", rv, 32'h76543210);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
